timer_responder: RTL and testbench



---
 rtl/timer_responder.sv | 74 +++++++
 tb/tb_timer_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/timer_responder.sv
// timer_responder: memory-mapped countdown timer with preset, auto-reload and interrupt request
module timer_responder #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, CNT, INT} state_t;
  state_t state, state_n;
  logic [3:0] ctrl;
  logic [31:0] preset, count, count_n;
  logic irq_pend, pend_set, en_clr, wr_ctrl, wr_preset, unused;
  assign unused = ^addr[1:0];
  assign wr_ctrl = we & hit & (addr[3:2] == 2'd0);
  assign wr_preset = we & hit & (addr[3:2] == 2'd1);
  // A CTRL write overrides the whole FSM step; a PRESET write only overrides irq_pend
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      irq_pend <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl <= wdata[3:0];
      state <= IDLE;
      irq_pend <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (en_clr) ctrl[0] <= 1'b0;
      irq_pend <= ~wr_preset & (irq_pend | pend_set);
      if (wr_preset) preset <= wdata;
    end
  always_comb begin
    state_n = state;
    count_n = count;
    pend_set = 1'b0;
    en_clr = 1'b0;
    case (state)
      IDLE: if (ctrl[0]) begin
        state_n = CNT;
        count_n = preset;
      end
      CNT: if (!ctrl[0]) state_n = IDLE;
        else if (count <= 32'd1) begin
          count_n = '0;
          pend_set = 1'b1;
          state_n = INT;
        end else count_n = count - 32'd1;
      INT: if (ctrl[2:1] == 2'd1) begin
        state_n = CNT;
        count_n = preset;
      end else begin
        state_n = IDLE;
        en_clr = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    hit = addr[31:4] == BASE[31:4];
    rdata = addr[3:2] == 2'd0 ? {28'd0, ctrl} :
            addr[3:2] == 2'd1 ? preset :
            addr[3:2] == 2'd2 ? count : 32'd0;
    irq = irq_pend & ctrl[3];
  end
endmodule

// File: tb/tb_timer_responder.sv
// tb_timer_responder: directed scenario tests for timer_responder
module tb_timer_responder;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, hit, irq;
  logic [31:0] addr = 32'h7F00, wdata = '0, rdata, d;
  int tests = 0, fails = 0;
  timer_responder dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
                       .hit(hit), .rdata(rdata), .irq(irq));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addr = a; wdata = v; we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; we = 1'b0;
    #1;
    v = rdata;
  endtask
  task automatic test_reset;
    logic [31:0] ha [5] = '{32'h7F00, 32'h7F0F, 32'h7EFF, 32'h7F10, 32'h0};
    logic hx [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(32'h7F00 + 32'(4 * i), d);
      tests++;
      if (d !== 32'd0) begin fails++; $display("FAIL reset_reg%0d got %h want 0", i, d); end
    end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
    for (int i = 0; i < 5; i++) begin
      addr = ha[i];
      #1;
      tests++;
      if (hit !== hx[i]) begin fails++; $display("FAIL hit_%h got %b want %b", ha[i], hit, hx[i]); end
    end
  endtask
  task automatic test_oneshot;
    wr(32'h7F04, 5);
    wr(32'h7F00, 32'h9);
    for (int i = 1; i <= 6; i++) begin
      tick();
      rd(32'h7F08, d);
      tests++;
      if (d !== 32'(6 - i)) begin fails++; $display("FAIL oneshot_count_e%0d got %0d want %0d", i, d, 6 - i); end
      tests++;
      if (irq !== (i == 6)) begin fails++; $display("FAIL oneshot_irq_e%0d got %b want %b", i, irq, i == 6); end
    end
    tick();
    rd(32'h7F00, d);
    tests++;
    if (d !== 32'h8) begin fails++; $display("FAIL oneshot_ctrl got %h want 8", d); end
    tick(2);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd0 || irq !== 1'b1) begin fails++; $display("FAIL oneshot_hold count %0d irq %b want 0 1", d, irq); end
  endtask
  task automatic test_reload;
    logic [31:0] ec [9] = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    wr(32'h7F04, 2);
    wr(32'h7F00, 32'hB);
    for (int i = 0; i < 9; i++) begin
      tick();
      rd(32'h7F08, d);
      tests++;
      if (d !== ec[i] || irq !== (i >= 2)) begin
        fails++; $display("FAIL reload_e%0d count %0d irq %b want %0d %b", i + 1, d, irq, ec[i], i >= 2);
      end
    end
    wr(32'h7F04, 2);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd2 || irq !== 1'b0) begin fails++; $display("FAIL reload_clr count %0d irq %b want 2 0", d, irq); end
    tick();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reload_pre got %b want 0", irq); end
    tick();
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL reload_reraise got %b want 1", irq); end
  endtask
  task automatic test_preset_edges;
    for (int p = 0; p < 2; p++) begin
      wr(32'h7F04, 32'(p));
      wr(32'h7F00, 32'h9);
      tick();
      rd(32'h7F08, d);
      tests++;
      if (d !== 32'(p) || irq !== 1'b0) begin fails++; $display("FAIL p%0d_e1 count %0d irq %b want %0d 0", p, d, irq, p); end
      tick();
      rd(32'h7F08, d);
      tests++;
      if (d !== 32'd0 || irq !== 1'b1) begin fails++; $display("FAIL p%0d_e2 count %0d irq %b want 0 1", p, d, irq); end
      tick();
    end
  endtask
  task automatic test_stop;
    wr(32'h7F04, 10);
    wr(32'h7F00, 32'h1);
    tick(3);
    wr(32'h7F00, 32'h0);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd8) begin fails++; $display("FAIL stop_count got %0d want 8", d); end
    tick(5);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd8 || irq !== 1'b0) begin fails++; $display("FAIL stop_frozen count %0d irq %b want 8 0", d, irq); end
  endtask
  task automatic test_collide;
    wr(32'h7F04, 3);
    wr(32'h7F00, 32'h1);
    tick(3);
    wr(32'h7F00, 32'h8);
    rd(32'h7F00, d);
    tests++;
    if (d !== 32'h8 || irq !== 1'b0) begin fails++; $display("FAIL collide ctrl %h irq %b want 8 0", d, irq); end
    tick(3);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd1 || irq !== 1'b0) begin fails++; $display("FAIL collide_idle count %0d irq %b want 1 0", d, irq); end
  endtask
  task automatic test_ignore;
    wr(32'h7F04, 7);
    wr(32'h7F00, 32'h1);
    tick();
    wr(32'h7F00, 32'h0);
    wr(32'h7F08, 32'h1234);
    wr(32'h7F0C, 32'hFFFF_FFFF);
    wr(32'h8F00, 32'hF);
    wr(32'h7F14, 32'h99);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd7) begin fails++; $display("FAIL ignore_count got %0d want 7", d); end
    rd(32'h7F0C, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL ignore_reg3 got %h want 0", d); end
    rd(32'h7F00, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL ignore_ctrl got %h want 0", d); end
    rd(32'h7F04, d);
    tests++;
    if (d !== 32'd7) begin fails++; $display("FAIL ignore_preset got %h want 7", d); end
  endtask
  task automatic test_reset_mid;
    wr(32'h7F04, 20);
    wr(32'h7F00, 32'h9);
    tick(3);
    reset = 1'b1; addr = 32'h7F04; wdata = 32'h55; we = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(32'h7F00 + 32'(4 * i), d);
      tests++;
      if (d !== 32'd0) begin fails++; $display("FAIL rstmid_reg%0d got %h want 0", i, d); end
    end
    tick(3);
    rd(32'h7F08, d);
    tests++;
    if (d !== 32'd0 || irq !== 1'b0) begin fails++; $display("FAIL rstmid_idle count %0d irq %b want 0 0", d, irq); end
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_preset_edges();
    test_stop();
    test_collide();
    test_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
